// File: rtl/ac_rle_pkg.sv
// Shared types and helpers for the JPEG AC run-length encoder.
// This covers the FSM state encoding, the ZRL/EOB symbol constants and the amplitude bit encoding.
package ac_rle_pkg;

  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_ZRL = 1'b1
  } state_e;

  // Widest coefficient the amplitude helper can encode.
  localparam int AMP_MAX_W = 32;

  localparam int ZRL_SIZE = 0;
  localparam int EOB_RUN  = 0;
  localparam int EOB_SIZE = 0;

  // A ZRL symbol carries the maximum run value and stands for run+1 zeros.
  function automatic int zrl_run(input int run_w);
    return (1 << run_w) - 1;
  endfunction

  // JPEG amplitude bits.
  // A positive value is sent as is. A negative value is sent as the low `size` bits of (coef - 1).
  function automatic logic [AMP_MAX_W-1:0] amp_encode(
    input logic signed [AMP_MAX_W-1:0] coef,
    input int                          size
  );
    logic [AMP_MAX_W-1:0] mask;
    logic [AMP_MAX_W-1:0] raw;
    mask = ~({AMP_MAX_W{1'b1}} << size);
    raw  = coef[AMP_MAX_W-1] ? coef - 1 : coef;
    return raw & mask;
  endfunction

endpackage

// File: rtl/coef_size_cat.sv
// Combinational size-category priority encoder.
// Maps a signed coefficient to its JPEG size category and its right-aligned amplitude bits.
module coef_size_cat
  import ac_rle_pkg::*;
#(
  parameter int COEF_W = 12,
  parameter int SIZE_W = 4
) (
  input  logic signed [COEF_W-1:0] coef_i,
  output logic        [SIZE_W-1:0] size_o,
  output logic        [COEF_W-1:0] amp_o
);

  logic [COEF_W-1:0] mag;

  // The most negative value wraps to itself, which is still the correct unsigned magnitude.
  always_comb begin
    mag = coef_i[COEF_W-1] ? (~coef_i + 1'b1) : coef_i;
  end

  always_comb begin
    size_o = '0;
    for (int i = 0; i < COEF_W; i++) begin
      if (mag[i]) begin
        size_o = SIZE_W'(i + 1);
      end
    end
  end

  assign amp_o = COEF_W'(amp_encode(AMP_MAX_W'(coef_i), int'(size_o)));

endmodule

// File: rtl/ac_rle_stream.sv
// Streaming AC run-length encoder with valid/ready on both sides.
// Consumes zig-zag AC coefficients and emits (run, size, amp) symbols, inserting ZRL and EOB.
module ac_rle_stream
  import ac_rle_pkg::*;
#(
  parameter int COEF_W = 12,
  parameter int AC_LEN = 63,
  parameter int RUN_W  = 4,
  parameter int SIZE_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     coef_valid_i,
  output logic                     coef_ready_o,
  input  logic signed [COEF_W-1:0] coef_data_i,
  output logic                     sym_valid_o,
  input  logic                     sym_ready_i,
  output logic        [RUN_W-1:0]  sym_run_o,
  output logic        [SIZE_W-1:0] sym_size_o,
  output logic        [COEF_W-1:0] sym_amp_o,
  output logic                     sym_last_o,
  output logic                     blk_done_o
);

  localparam int IDX_W = (AC_LEN > 1) ? $clog2(AC_LEN) : 1;
  localparam int Z_W   = $clog2(AC_LEN + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(AC_LEN - 1);
  localparam logic [RUN_W-1:0]  ZRL_RUN_C  = RUN_W'(zrl_run(RUN_W));
  localparam logic [SIZE_W-1:0] ZRL_SIZE_C = SIZE_W'(ZRL_SIZE);
  localparam logic [RUN_W-1:0]  EOB_RUN_C  = RUN_W'(EOB_RUN);
  localparam logic [SIZE_W-1:0] EOB_SIZE_C = SIZE_W'(EOB_SIZE);

  state_e state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [Z_W-1:0]    z_q, z_d;
  logic [Z_W-1:0]    zrl_cnt_q, zrl_cnt_d;

  logic              sym_valid_q, sym_valid_d;
  logic [RUN_W-1:0]  sym_run_q, sym_run_d;
  logic [SIZE_W-1:0] sym_size_q, sym_size_d;
  logic [COEF_W-1:0] sym_amp_q, sym_amp_d;
  logic              sym_last_q, sym_last_d;

  logic [RUN_W-1:0]  hold_run_q, hold_run_d;
  logic [SIZE_W-1:0] hold_size_q, hold_size_d;
  logic [COEF_W-1:0] hold_amp_q, hold_amp_d;
  logic              hold_last_q, hold_last_d;

  logic [SIZE_W-1:0] cat_size;
  logic [COEF_W-1:0] cat_amp;

  coef_size_cat #(
    .COEF_W (COEF_W),
    .SIZE_W (SIZE_W)
  ) u_size_cat (
    .coef_i (coef_data_i),
    .size_o (cat_size),
    .amp_o  (cat_amp)
  );

  logic                   out_hs;
  logic                   out_free;
  logic                   acc_ready;
  logic                   accept;
  logic                   coef_nz;
  logic                   at_last;
  logic                   zrl_final;
  logic [Z_W+RUN_W-1:0]   z_ext;
  logic [Z_W+RUN_W-1:0]   k_ext;
  logic [RUN_W-1:0]       run_c;
  logic [Z_W-1:0]         zrl_k;

  assign out_hs    = sym_valid_q && sym_ready_i;
  assign out_free  = !sym_valid_q || sym_ready_i;
  assign acc_ready = (state_q == S_ACC) && out_free;
  assign accept    = coef_valid_i && acc_ready;
  assign coef_nz   = |coef_data_i;
  assign at_last   = (idx_q == LAST_IDX);
  assign zrl_final = (zrl_cnt_q == Z_W'(1));

  // The low RUN_W bits of the zero count become the run field.
  // The remaining high bits give the number of ZRL symbols to send before the value.
  assign z_ext = (Z_W + RUN_W)'(z_q);
  assign k_ext = z_ext >> RUN_W;
  assign run_c = z_ext[RUN_W-1:0];
  assign zrl_k = k_ext[Z_W-1:0];

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC: begin
        if (accept && coef_nz && (zrl_k != '0)) begin
          state_d = S_ZRL;
        end
      end
      S_ZRL: begin
        if (out_hs && zrl_final) begin
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  // Counters, held symbol and output register
  always_comb begin
    idx_d       = idx_q;
    z_d         = z_q;
    zrl_cnt_d   = zrl_cnt_q;
    sym_valid_d = sym_valid_q && !sym_ready_i;
    sym_run_d   = sym_run_q;
    sym_size_d  = sym_size_q;
    sym_amp_d   = sym_amp_q;
    sym_last_d  = sym_last_q;
    hold_run_d  = hold_run_q;
    hold_size_d = hold_size_q;
    hold_amp_d  = hold_amp_q;
    hold_last_d = hold_last_q;

    case (state_q)
      S_ACC: begin
        if (accept) begin
          idx_d = at_last ? '0 : idx_q + 1'b1;
          if (!coef_nz) begin
            if (at_last) begin
              z_d         = '0;
              sym_valid_d = 1'b1;
              sym_run_d   = EOB_RUN_C;
              sym_size_d  = EOB_SIZE_C;
              sym_amp_d   = '0;
              sym_last_d  = 1'b1;
            end else begin
              z_d = z_q + 1'b1;
            end
          end else begin
            z_d = '0;
            if (zrl_k == '0) begin
              sym_valid_d = 1'b1;
              sym_run_d   = run_c;
              sym_size_d  = cat_size;
              sym_amp_d   = cat_amp;
              sym_last_d  = at_last;
            end else begin
              hold_run_d  = run_c;
              hold_size_d = cat_size;
              hold_amp_d  = cat_amp;
              hold_last_d = at_last;
              zrl_cnt_d   = zrl_k;
              sym_valid_d = 1'b1;
              sym_run_d   = ZRL_RUN_C;
              sym_size_d  = ZRL_SIZE_C;
              sym_amp_d   = '0;
              sym_last_d  = 1'b0;
            end
          end
        end
      end
      S_ZRL: begin
        if (out_hs) begin
          zrl_cnt_d   = zrl_cnt_q - 1'b1;
          sym_valid_d = 1'b1;
          if (zrl_final) begin
            sym_run_d  = hold_run_q;
            sym_size_d = hold_size_q;
            sym_amp_d  = hold_amp_q;
            sym_last_d = hold_last_q;
          end else begin
            sym_run_d  = ZRL_RUN_C;
            sym_size_d = ZRL_SIZE_C;
            sym_amp_d  = '0;
            sym_last_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q       <= '0;
      z_q         <= '0;
      zrl_cnt_q   <= '0;
      sym_valid_q <= 1'b0;
      sym_run_q   <= '0;
      sym_size_q  <= '0;
      sym_amp_q   <= '0;
      sym_last_q  <= 1'b0;
      hold_run_q  <= '0;
      hold_size_q <= '0;
      hold_amp_q  <= '0;
      hold_last_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      z_q         <= z_d;
      zrl_cnt_q   <= zrl_cnt_d;
      sym_valid_q <= sym_valid_d;
      sym_run_q   <= sym_run_d;
      sym_size_q  <= sym_size_d;
      sym_amp_q   <= sym_amp_d;
      sym_last_q  <= sym_last_d;
      hold_run_q  <= hold_run_d;
      hold_size_q <= hold_size_d;
      hold_amp_q  <= hold_amp_d;
      hold_last_q <= hold_last_d;
    end
  end

  // Output logic
  // Ready is gated by reset so the input side is closed while reset is asserted.
  always_comb begin
    coef_ready_o = rst_n_i && acc_ready;
    sym_valid_o  = sym_valid_q;
    sym_run_o    = sym_run_q;
    sym_size_o   = sym_size_q;
    sym_amp_o    = sym_amp_q;
    sym_last_o   = sym_last_q;
    blk_done_o   = out_hs && sym_last_q;
  end

endmodule
